pipe_stage_sequencer: RTL



---
 rtl/beta_pkg.sv | 15 +
 rtl/pipe_stage_sequencer_if.sv | 26 ++
 rtl/beta_instr_decode.sv | 26 ++
 rtl/pipe_stage_sequencer.sv | 99 +++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// beta_pkg: shared Beta opcode constants, instruction field positions and register type
package beta_pkg;
  localparam logic [5:0] OPC_ST = 6'h19;
  localparam logic [5:0] OPC_HALT = 6'h3F;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RC_HI = 25;
  localparam int RC_LO = 21;
  localparam int RA_HI = 20;
  localparam int RA_LO = 16;
  localparam int RB_HI = 15;
  localparam int RB_LO = 11;
  localparam logic [4:0] REG_ZERO = 5'd31;
  typedef logic [4:0] reg_t;
endpackage

// File: rtl/pipe_stage_sequencer_if.sv
// pipe_stage_sequencer_if: fetch handshake, branch input and per-stage control outputs
interface pipe_stage_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W = 32,
  parameter int RETIRE_W = 16
);
  logic run;
  logic fetch_valid;
  logic [DATA_W-1:0] fetch_instr;
  logic fetch_ready;
  logic branch_taken;
  logic [NUM_STAGES-1:0] stage_valid;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES*DATA_W-1:0] stage_instr;
  logic stall;
  logic halted;
  logic [RETIRE_W-1:0] retire_count;
  modport master (
    output run, fetch_valid, fetch_instr, branch_taken,
    input fetch_ready, stage_valid, stage_en, stage_instr, stall, halted, retire_count
  );
  modport slave (
    input run, fetch_valid, fetch_instr, branch_taken,
    output fetch_ready, stage_valid, stage_en, stage_instr, stall, halted, retire_count
  );
endinterface

// File: rtl/beta_instr_decode.sv
// beta_instr_decode: register read/write fields of one Beta instruction
module beta_instr_decode
  import beta_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        writes_rf_o,
  output reg_t        dest_o,
  output reg_t        src_a_o,
  output reg_t        src_b_o,
  output logic        src_b_used_o,
  output logic        is_halt_o
);
  logic [5:0] opc;
  logic is_st;
  logic unused_lsbs;
  assign opc = instr_i[OPC_HI:OPC_LO];
  assign is_st = opc == OPC_ST;
  assign is_halt_o = opc == OPC_HALT;
  assign writes_rf_o = ~(is_st | is_halt_o);
  assign dest_o = instr_i[RC_HI:RC_LO];
  assign src_a_o = instr_i[RA_HI:RA_LO];
  // stores read the value register through the rc field
  assign src_b_o = is_st ? instr_i[RC_HI:RC_LO] : instr_i[RB_HI:RB_LO];
  assign src_b_used_o = (opc[5:4] == 2'b10) | is_st;
  assign unused_lsbs = ^instr_i[RB_LO-1:0];
endmodule

// File: rtl/pipe_stage_sequencer.sv
// pipe_stage_sequencer: valid-bit pipeline control with RAW stall, branch flush, HALT and retire count
module pipe_stage_sequencer
  import beta_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W = 32,
  parameter int RETIRE_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_stage_sequencer_if.slave bus
);
  localparam int NS = NUM_STAGES;
  logic [NS-1:0] valid_q, valid_d, in_v, hit, en;
  logic [DATA_W-1:0] instr_q [NS];
  logic [DATA_W-1:0] instr_d [NS];
  logic [DATA_W-1:0] in_i [NS];
  logic halted_q, halted_d;
  logic [RETIRE_W-1:0] cnt_q, cnt_d;
  logic writes_rf [NS];
  logic src_b_used [NS];
  logic is_halt [NS];
  reg_t dest [NS];
  reg_t src_a [NS];
  reg_t src_b [NS];
  logic [NS*DATA_W-1:0] flat;
  logic run_g, active, stall, flush, accept, retire, unused_dec;
  for (genvar s = 0; s < NS; s++) begin : g_dec
    beta_instr_decode u_dec (
      .instr_i      (instr_q[s][31:0]),
      .writes_rf_o  (writes_rf[s]),
      .dest_o       (dest[s]),
      .src_a_o      (src_a[s]),
      .src_b_o      (src_b[s]),
      .src_b_used_o (src_b_used[s]),
      .is_halt_o    (is_halt[s])
    );
  end
  // no bypass network: every older writer, including the writeback stage, blocks stage 1
  always_comb begin
    hit = '0;
    unused_dec = 1'b0;
    for (int s = 2; s < NS; s++)
      hit[s] = valid_q[s] & writes_rf[s] & (dest[s] != REG_ZERO) &
               ((dest[s] == src_a[1]) | (src_b_used[1] & (dest[s] == src_b[1])));
    for (int s = 0; s < NS; s++)
      unused_dec ^= writes_rf[s] ^ is_halt[s] ^ src_b_used[s] ^ (^{dest[s], src_a[s], src_b[s]});
  end
  assign run_g = bus.run & ~rst;
  assign active = run_g & ~halted_q;
  assign stall = run_g & valid_q[1] & ~bus.branch_taken & (|hit);
  assign flush = run_g & valid_q[2] & bus.branch_taken;
  assign bus.fetch_ready = active & ~stall;
  assign accept = bus.fetch_valid & bus.fetch_ready;
  assign retire = active & valid_q[NS-1];
  always_comb begin
    in_v[0] = accept & ~flush;
    in_i[0] = flush ? '0 : bus.fetch_instr;
    in_v[1] = valid_q[0] & ~flush;
    in_i[1] = flush ? '0 : instr_q[0];
    in_v[2] = valid_q[1] & ~stall;
    in_i[2] = stall ? '0 : instr_q[1];
    for (int s = 3; s < NS; s++) begin
      in_v[s] = valid_q[s-1];
      in_i[s] = instr_q[s-1];
    end
    for (int s = 0; s < NS; s++) begin
      valid_d[s] = ~run_g ? 1'b0 : (halted_q | ((s < 2) & stall)) ? valid_q[s] : in_v[s];
      instr_d[s] = (~run_g | halted_q | ((s < 2) & stall)) ? instr_q[s] : in_i[s];
      en[s] = active & ~((s < 2) & stall) & in_v[s];
    end
    en[0] = accept;
    halted_d = run_g & (halted_q | (retire & is_halt[NS-1]));
    cnt_d = cnt_q + RETIRE_W'(retire);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      instr_q <= '{default: '0};
      halted_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      halted_q <= halted_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    flat = '0;
    for (int s = 0; s < NS; s++) flat[s*DATA_W +: DATA_W] = instr_q[s];
  end
  assign bus.stage_instr = flat;
  assign bus.stage_valid = valid_q;
  assign bus.stage_en = en;
  assign bus.stall = stall;
  assign bus.halted = halted_q;
  assign bus.retire_count = cnt_q;
endmodule
